// File: rtl/hilo_unit.sv
// rtl/hilo_unit.sv - HI/LO register unit with iterative multiply/divide (optional MADD/MSUB via HILO_MADD_EN)
module hilo_unit #(
    parameter int WIDTH      = 32,
    parameter int COUNT_BITS = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             op_start,
    input  logic [2:0]       op_code,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic             cancel,
    input  logic             write_hi_enable,
    input  logic [WIDTH-1:0] write_hi_data,
    input  logic             write_lo_enable,
    input  logic [WIDTH-1:0] write_lo_data,
    output logic [WIDTH-1:0] hi_data,
    output logic [WIDTH-1:0] lo_data,
    output logic             op_busy,
    output logic             op_done
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [COUNT_BITS-1:0] count_q, count_d;
    logic [2:0]            op_q, op_d;
    logic [WIDTH-1:0]      a_mag_q, a_mag_d;
    logic [WIDTH-1:0]      b_mag_q, b_mag_d;
    logic [WIDTH-1:0]      acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0]      acc_lo_q, acc_lo_d;
    logic                  neg_q, neg_d;
    logic                  neg_rem_q, neg_rem_d;
    logic [WIDTH-1:0]      hi_q, hi_d;
    logic [WIDTH-1:0]      lo_q, lo_d;
    logic                  done_q, done_d;

    logic                  start_signed, a_neg, b_neg, op_valid, start_is_div;
    logic [WIDTH-1:0]      a_abs, b_abs;
    logic [WIDTH:0]        mul_sum;
    logic [WIDTH:0]        div_shift;
    logic [WIDTH-1:0]      div_diff;
    logic                  div_ge;
    logic                  is_div;
    logic [2*WIDTH-1:0]    prod_s;
    logic [WIDTH-1:0]      res_hi, res_lo;

    // Operand magnitudes and sign flags for a starting operation
    always_comb begin
        start_signed = ~op_code[0];
        a_neg        = start_signed & operand_a[WIDTH-1];
        b_neg        = start_signed & operand_b[WIDTH-1];
        a_abs        = a_neg ? -operand_a : operand_a;
        b_abs        = b_neg ? -operand_b : operand_b;
        start_is_div = ~op_code[2] & op_code[1];
`ifdef HILO_MADD_EN
        op_valid     = 1'b1;
`else
        op_valid     = ~op_code[2];
`endif
    end

    // One shift-add / restoring subtract-shift step and the final sign-corrected result
    always_comb begin
        is_div    = ~op_q[2] & op_q[1];
        mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, a_mag_q} : {(WIDTH+1){1'b0}});
        div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
        div_ge    = div_shift >= {1'b0, b_mag_q};
        div_diff  = div_shift[WIDTH-1:0] - b_mag_q;
        prod_s    = neg_q ? -{acc_hi_q, acc_lo_q} : {acc_hi_q, acc_lo_q};
        if (is_div) begin
            if (b_mag_q == '0) begin
                // Divide by zero returns the original dividend and an all-ones quotient
                res_hi = neg_rem_q ? -a_mag_q : a_mag_q;
                res_lo = '1;
            end else begin
                res_hi = neg_rem_q ? -acc_hi_q : acc_hi_q;
                res_lo = neg_q ? -acc_lo_q : acc_lo_q;
            end
        end else begin
            {res_hi, res_lo} = prod_s;
`ifdef HILO_MADD_EN
            // HI/LO cannot change during RUN without aborting, so they still hold the start value
            if (op_q[2]) begin
                {res_hi, res_lo} = op_q[1] ? ({hi_q, lo_q} - prod_s) : ({hi_q, lo_q} + prod_s);
            end
`endif
        end
    end

    // Next-state: FSM sequencing, iteration, result write-back and direct mthi/mtlo writes
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        op_d      = op_q;
        a_mag_d   = a_mag_q;
        b_mag_d   = b_mag_q;
        acc_hi_d  = acc_hi_q;
        acc_lo_d  = acc_lo_q;
        neg_d     = neg_q;
        neg_rem_d = neg_rem_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (op_start && !cancel && op_valid) begin
                    state_d   = S_RUN;
                    count_d   = '0;
                    op_d      = op_code;
                    a_mag_d   = a_abs;
                    b_mag_d   = b_abs;
                    neg_d     = a_neg ^ b_neg;
                    neg_rem_d = a_neg;
                    acc_hi_d  = '0;
                    acc_lo_d  = start_is_div ? a_abs : b_abs;
                end
            end
            S_RUN: begin
                if (cancel || write_hi_enable || write_lo_enable) begin
                    state_d = S_IDLE;
                end else begin
                    if (is_div) begin
                        acc_hi_d = div_ge ? div_diff : div_shift[WIDTH-1:0];
                        acc_lo_d = {acc_lo_q[WIDTH-2:0], div_ge};
                    end else begin
                        acc_hi_d = mul_sum[WIDTH:1];
                        acc_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
                    end
                    count_d = count_q + 1'b1;
                    if (count_q == COUNT_BITS'(WIDTH-1)) begin
                        state_d = S_FIX;
                    end
                end
            end
            S_FIX: begin
                state_d = S_IDLE;
                if (!cancel) begin
                    hi_d   = res_hi;
                    lo_d   = res_lo;
                    done_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // A direct write always lands on its own register, overriding any op result
        if (write_hi_enable) hi_d = write_hi_data;
        if (write_lo_enable) lo_d = write_lo_data;
    end

    // State registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            count_q   <= '0;
            op_q      <= '0;
            a_mag_q   <= '0;
            b_mag_q   <= '0;
            acc_hi_q  <= '0;
            acc_lo_q  <= '0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            op_q      <= op_d;
            a_mag_q   <= a_mag_d;
            b_mag_q   <= b_mag_d;
            acc_hi_q  <= acc_hi_d;
            acc_lo_q  <= acc_lo_d;
            neg_q     <= neg_d;
            neg_rem_q <= neg_rem_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
        end
    end

    assign hi_data = hi_q;
    assign lo_data = lo_q;
    assign op_busy = state_q != S_IDLE;
    assign op_done = done_q;
endmodule

// File: tb/tb_hilo_unit.sv
// tb/tb_hilo_unit.sv - directed table-driven bench for hilo_unit
module tb_hilo_unit;
    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        op_start = 1'b0;
    logic [2:0]  op_code = 3'd0;
    logic [31:0] operand_a = '0;
    logic [31:0] operand_b = '0;
    logic        cancel = 1'b0;
    logic        write_hi_enable = 1'b0;
    logic [31:0] write_hi_data = '0;
    logic        write_lo_enable = 1'b0;
    logic [31:0] write_lo_data = '0;
    logic [31:0] hi_data, lo_data;
    logic        op_busy, op_done;

    int n_vec  = 0;
    int n_fail = 0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs [14];

    hilo_unit #(.WIDTH(32), .COUNT_BITS(6)) dut (
        .clock(clock), .reset(reset), .op_start(op_start), .op_code(op_code),
        .operand_a(operand_a), .operand_b(operand_b), .cancel(cancel),
        .write_hi_enable(write_hi_enable), .write_hi_data(write_hi_data),
        .write_lo_enable(write_lo_enable), .write_lo_data(write_lo_data),
        .hi_data(hi_data), .lo_data(lo_data), .op_busy(op_busy), .op_done(op_done)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        op_code   = op;
        operand_a = a;
        operand_b = b;
        op_start  = 1'b1;
        step();
        op_start  = 1'b0;
    endtask

    // Counts op_done pulses over n cycles
    task automatic watch_done(input int n, output int pulses);
        pulses = 0;
        for (int i = 0; i < n; i++) begin
            step();
            if (op_done) pulses++;
        end
    endtask

    task automatic run_vec(input string name, input vec_t v);
        int busy_cycles;
        int guard;
        start_op(v.op, v.a, v.b);
        busy_cycles = op_busy ? 1 : 0;
        guard = 0;
        while (!op_done && guard < 100) begin
            step();
            if (op_busy) busy_cycles++;
            guard++;
        end
        chk({name, "_done_seen"}, {31'd0, op_done}, 32'd1);
        chk({name, "_busy_cycles"}, busy_cycles, 32'd33);
        chk({name, "_hi"}, hi_data, v.hi);
        chk({name, "_lo"}, lo_data, v.lo);
        step();
        chk({name, "_done_single"}, {31'd0, op_done}, 32'd0);
    endtask

    initial begin
        int pulses;
        vecs[0]  = '{OP_MULTU, 32'hFFFF0000, 32'h05050000, 32'h0504FAFB, 32'h00000000};
        vecs[1]  = '{OP_MULT,  32'hFFFF0000, 32'h05050000, 32'hFFFFFAFB, 32'h00000000};
        vecs[2]  = '{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3]  = '{OP_DIVU,  32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003};
        vecs[4]  = '{OP_DIV,   32'h12345678, 32'h00000000, 32'h12345678, 32'hFFFFFFFF};
        vecs[5]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[6]  = '{OP_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        vecs[7]  = '{OP_DIV,   32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003};
        vecs[8]  = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[9]  = '{OP_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
        vecs[10] = '{OP_DIVU,  32'hFFFFFFFF, 32'h0000000A, 32'h00000005, 32'h19999999};
        vecs[11] = '{OP_DIVU,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000};
        vecs[12] = '{OP_DIV,   32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF};
        vecs[13] = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};

        // Reset state
        step();
        step();
        chk("reset_hi", hi_data, 32'h0);
        chk("reset_lo", lo_data, 32'h0);
        chk("reset_busy", {31'd0, op_busy}, 32'd0);
        chk("reset_done", {31'd0, op_done}, 32'd0);
        reset = 1'b1;
        step();

        // mthi then mtlo
        write_hi_enable = 1'b1; write_hi_data = 32'hFFFF0000;
        step();
        write_hi_enable = 1'b0;
        chk("mthi_hi", hi_data, 32'hFFFF0000);
        chk("mthi_lo", lo_data, 32'h0);
        write_lo_enable = 1'b1; write_lo_data = 32'h05050000;
        step();
        write_lo_enable = 1'b0;
        chk("mtlo_lo", lo_data, 32'h05050000);
        chk("mtlo_hi", hi_data, 32'hFFFF0000);
        chk("mt_busy", {31'd0, op_busy}, 32'd0);

        // Cancel at cycle 5 of a MULTU
        start_op(OP_MULTU, 32'd3, 32'd5);
        chk("cancel_busy_start", {31'd0, op_busy}, 32'd1);
        for (int i = 0; i < 4; i++) step();
        cancel = 1'b1;
        step();
        cancel = 1'b0;
        chk("cancel_busy", {31'd0, op_busy}, 32'd0);
        watch_done(40, pulses);
        chk("cancel_no_done", pulses, 32'd0);
        chk("cancel_hi", hi_data, 32'hFFFF0000);
        chk("cancel_lo", lo_data, 32'h05050000);

        // mtlo at cycle 8 of a MULTU aborts it
        start_op(OP_MULTU, 32'd3, 32'd5);
        for (int i = 0; i < 7; i++) step();
        write_lo_enable = 1'b1; write_lo_data = 32'hAAAA5555;
        step();
        write_lo_enable = 1'b0;
        chk("mtlo_abort_lo", lo_data, 32'hAAAA5555);
        chk("mtlo_abort_hi", hi_data, 32'hFFFF0000);
        chk("mtlo_abort_busy", {31'd0, op_busy}, 32'd0);
        watch_done(40, pulses);
        chk("mtlo_abort_no_done", pulses, 32'd0);
        chk("mtlo_abort_lo_kept", lo_data, 32'hAAAA5555);

        // Table-driven arithmetic vectors
        for (int i = 0; i < 14; i++) begin
            run_vec($sformatf("vec%0d", i), vecs[i]);
        end

        // mthi on the FIX edge: HI takes the write, LO takes the product
        start_op(OP_MULTU, 32'd3, 32'd5);
        for (int i = 0; i < 32; i++) step();
        chk("fix_busy", {31'd0, op_busy}, 32'd1);
        write_hi_enable = 1'b1; write_hi_data = 32'h0000BEEF;
        step();
        write_hi_enable = 1'b0;
        chk("fix_write_hi", hi_data, 32'h0000BEEF);
        chk("fix_write_lo", lo_data, 32'h0000000F);
        chk("fix_write_done", {31'd0, op_done}, 32'd1);
        chk("fix_write_busy", {31'd0, op_busy}, 32'd0);

`ifdef HILO_MADD_EN
        write_hi_enable = 1'b1; write_hi_data = 32'h0;
        write_lo_enable = 1'b1; write_lo_data = 32'h5;
        step();
        write_hi_enable = 1'b0;
        write_lo_enable = 1'b0;
        run_vec("madd", '{3'd4, 32'd3, 32'd4, 32'h00000000, 32'h00000011});
        run_vec("msubu", '{3'd7, 32'd1, 32'd18, 32'hFFFFFFFF, 32'hFFFFFFFF});
`else
        // op_code 4 is invalid without the accumulate feature
        start_op(3'd4, 32'd3, 32'd4);
        chk("op4_busy", {31'd0, op_busy}, 32'd0);
        watch_done(40, pulses);
        chk("op4_no_done", pulses, 32'd0);
        chk("op4_hi", hi_data, 32'h0000BEEF);
        chk("op4_lo", lo_data, 32'h0000000F);
`endif

        // Asynchronous reset at cycle 10 of a MULTU
        start_op(OP_MULTU, 32'hFFFF0000, 32'h05050000);
        for (int i = 0; i < 9; i++) step();
        chk("pre_reset_busy", {31'd0, op_busy}, 32'd1);
        reset = 1'b0;
        #1;
        chk("async_reset_hi", hi_data, 32'h0);
        chk("async_reset_lo", lo_data, 32'h0);
        chk("async_reset_busy", {31'd0, op_busy}, 32'd0);
        step();
        step();
        reset = 1'b1;
        watch_done(40, pulses);
        chk("async_reset_no_done", pulses, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule

// File: doc/hilo_unit.md
Name: hilo_unit

Overview:
- Parametrised HI/LO register unit for the CPU execute stage.
- Holds HI and LO, accepts direct writes for mthi/mtlo, and runs iterative multi-cycle multiply/divide that update {HI,LO}.
- Drives a busy flag the pipeline uses to stall mfhi/mflo and a new multiply/divide until the result lands.

Parameters:
- WIDTH, 32, data width of HI, LO and operands (≥4, even).
- COUNT_BITS, 6, iteration counter width; must satisfy 2^COUNT_BITS > WIDTH.

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low (0 = reset)
- op_start  input  1  start multiply/divide; sampled only in IDLE
- op_code  input  3  0=MULT 1=MULTU 2=DIV 3=DIVU, 4-7 see Optional Feature, others ignored
- operand_a  input  WIDTH  rs value (multiplicand/dividend)
- operand_b  input  WIDTH  rt value (multiplier/divisor)
- cancel  input  1  abort in-flight op (exception flush)
- write_hi_enable  input  1  mthi strobe
- write_hi_data  input  WIDTH  mthi data
- write_lo_enable  input  1  mtlo strobe
- write_lo_data  input  WIDTH  mtlo data
- hi_data  output  WIDTH  current HI register
- lo_data  output  WIDTH  current LO register
- op_busy  output  1  op in flight
- op_done  output  1  one-cycle pulse when result written

Behaviour:
- Reset (async, reset=0): hi_data=0, lo_data=0, op_busy=0, op_done=0, FSM=IDLE, counter=0, internal operands cleared.
- FSM states: IDLE, RUN, FIX.
- IDLE -> RUN: on edge with op_start=1 and valid op_code. Latch magnitudes, sign flags, opcode; counter=0; op_busy=1 after the edge. Invalid op_code: no action.
- RUN: one shift-add (multiply) or restoring subtract-shift (divide) per cycle. After WIDTH iterations -> FIX.
- FIX: apply sign correction (signed ops), write {HI,LO}, op_done=1 for exactly that following cycle, op_busy=0, -> IDLE.
- Latency: op_busy high for WIDTH+1 cycles. New HI/LO visible on hi_data/lo_data in the same cycle op_done=1.
- Multiply result: HI = upper WIDTH bits, LO = lower WIDTH bits of the 2*WIDTH product.
- Divide result: LO = quotient truncated toward zero, HI = remainder with the sign of the dividend.
- Divide by zero: HI = operand_a, LO = all ones; latency unchanged.
- Signed overflow (most-negative / -1): LO = most-negative, HI = 0.
- op_start while busy: ignored.
- cancel=1: FSM -> IDLE next edge, no HI/LO update, no op_done. cancel in IDLE: no effect. cancel has priority over op_start on the same edge.
- Direct writes: write_hi_enable / write_lo_enable update their register on the edge and are independent of each other.
  - A direct write while op_busy aborts the op exactly as cancel does; the written value persists.
  - Direct write on the FIX edge: the direct write wins for the written register; the other register takes the op result; op_done still pulses.
  - Direct write together with op_start in IDLE: the write applies and the op starts.
- hi_data/lo_data are pure register outputs, with no combinational path from inputs.

Optional Feature:
- Macro HILO_MADD_EN.
- Defined: op_code 4=MADD, 5=MADDU, 6=MSUB, 7=MSUBU. The product (signed/unsigned) is added to or subtracted from the {HI,LO} value captured at start, modulo 2^(2*WIDTH). Accumulation happens in FIX with no extra cycles.
- Undefined: op_code 4-7 are invalid and ignored in IDLE (no busy, no update).

Test Plan:
- Reset mid-RUN (cycle 10 of MULTU) -> hi_data=0, lo_data=0, op_busy=0 immediately; op_done never pulses.
- mthi 0xFFFF0000, then mtlo 0x05050000 -> hi_data=0xFFFF0000 after the first edge, lo_data=0x05050000 after the second; no busy.
- MULTU a=0xFFFF0000 b=0x05050000 -> op_busy for 33 cycles, op_done pulse, HI=0x0504FAFB LO=0x00000000. MULT same operands -> HI=0xFFFFFAFB LO=0x00000000.
- DIV a=0xFFFFFFF9(-7) b=2 -> LO=0xFFFFFFFD HI=0xFFFFFFFF. DIVU a=7 b=2 -> LO=3 HI=1. DIV a=0x12345678 b=0 -> HI=0x12345678 LO=0xFFFFFFFF.
- MULTU started, cancel at cycle 5 -> HI/LO keep prior values, no op_done. Second MULTU with mtlo 0xAAAA5555 at cycle 8 -> LO=0xAAAA5555, HI unchanged, busy drops.
- HILO_MADD_EN: HI:LO=0:5, MADD a=3 b=4 -> HI=0 LO=17. MSUBU a=1 b=18 -> HI=0xFFFFFFFF LO=0xFFFFFFFF. Without the macro, op_code 4 -> op_busy stays 0.
